// File: rtl/frame_serializer_if.sv
// Word-in / byte-out handshake bundle for the UART word-link framer.
// slave is the framer side; master is the word source plus the UART TX engine.
interface frame_serializer_if #(
    parameter int DATA_BYTES = 4
);
    logic [8*DATA_BYTES-1:0] word_in;
    logic                    word_valid;
    logic                    word_ready;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic                    frame_done;
    logic                    collide;

    modport master (
        output word_in, word_valid, tx_ready,
        input  word_ready, tx_data, tx_valid, busy, frame_done, collide
    );

    modport slave (
        input  word_in, word_valid, tx_ready,
        output word_ready, tx_data, tx_valid, busy, frame_done, collide
    );
endinterface

// File: rtl/frame_serializer.sv
// Transmit-side framer: one word becomes DATA_BYTES bytes (MSB first) plus a TERM byte.
// Every output is a flop, so there is no combinational path from word_valid or tx_ready.
//
// state | meaning
// IDLE  | word_ready high, waiting for a word
// SEND  | presenting data bytes, then the terminator, one per handshake
// GAP   | enforced idle cycles after the terminator
module frame_serializer #(
    parameter int          DATA_BYTES = 4,
    parameter logic [7:0]  TERM       = 8'hFF,
    parameter int          GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    frame_serializer_if.slave bus
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int IW = $clog2(DATA_BYTES + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BYTES - 1);
    localparam logic [7:0]    GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state, state_n;
    logic [W-1:0]  sh, sh_n, sh_shift;
    logic [IW-1:0] idx, idx_n;
    logic [7:0]    gap_cnt, gap_n;
    logic [7:0]    tx_data_q, tx_data_n;
    logic          tx_valid_q, tx_valid_n;
    logic          word_ready_q, busy_q;
    logic          frame_done_q, frame_done_n;
    logic          collide_q, collide_n;
    logic          accept, handshake, term_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sh           <= '0;
            idx          <= '0;
            gap_cnt      <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            collide_q    <= 1'b0;
        end else begin
            state        <= state_n;
            sh           <= sh_n;
            idx          <= idx_n;
            gap_cnt      <= gap_n;
            tx_data_q    <= tx_data_n;
            tx_valid_q   <= tx_valid_n;
            word_ready_q <= (state_n == IDLE);
            busy_q       <= (state_n != IDLE);
            frame_done_q <= frame_done_n;
            collide_q    <= collide_n;
        end
    end

    always_comb begin
        state_n      = state;
        sh_n         = sh;
        idx_n        = idx;
        gap_n        = gap_cnt;
        tx_data_n    = tx_data_q;
        tx_valid_n   = tx_valid_q;
        frame_done_n = 1'b0;
        collide_n    = 1'b0;
        accept       = bus.word_valid & word_ready_q;
        handshake    = tx_valid_q & bus.tx_ready;
        sh_shift     = sh << 8;

        // A data byte equal to TERM is sent as-is; the flag warns of receiver misalignment.
        term_hit = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (bus.word_in[8*i +: 8] == TERM) term_hit = 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    sh_n       = bus.word_in;
                    idx_n      = '0;
                    tx_data_n  = bus.word_in[W-1 -: 8];
                    tx_valid_n = 1'b1;
                    collide_n  = term_hit;
                    state_n    = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx < LAST_DATA) begin
                        sh_n      = sh_shift;
                        idx_n     = idx + IW'(1);
                        tx_data_n = sh_shift[W-1 -: 8];
                    end else if (idx == LAST_DATA) begin
                        tx_data_n = TERM;
                        idx_n     = idx + IW'(1);
                    end else begin
                        tx_valid_n   = 1'b0;
                        tx_data_n    = '0;
                        idx_n        = '0;
                        frame_done_n = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gap_n   = GAP_LOAD;
                            state_n = GAP;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_n = IDLE;
                else                 gap_n   = gap_cnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.word_ready = word_ready_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.collide    = collide_q;
endmodule
